// File: rtl/tinysoc_user_module_pkg.sv
// Shared definitions for the tinysoc user-slot CPU.
// Holds the data/instruction/PC widths, the opcode and ALU funct encodings,
// the instruction field positions and the load/exec phase enum.
package tinysoc_user_module_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned INSTR_W = 12;
    localparam int unsigned PC_W    = 4;
    localparam int unsigned CHUNK_W = 6;
    localparam int unsigned CNT_W   = 5;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [PC_W-1:0]    pc_t;

    // Opcodes; every other encoding executes as a NOP.
    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_BEQZ = 3'b010;
    localparam logic [2:0] OP_IMM  = 3'b011;
    localparam logic [2:0] OP_JUMP = 3'b100;

    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_SUB  = 3'b001;
    localparam logic [2:0] FN_AND  = 3'b010;
    localparam logic [2:0] FN_OR   = 3'b011;
    localparam logic [2:0] FN_XOR  = 3'b100;
    localparam logic [2:0] FN_SHL  = 3'b101;
    localparam logic [2:0] FN_SHR  = 3'b110;
    localparam logic [2:0] FN_PASS = 3'b111;

    // Instruction field positions.
    localparam int unsigned OP_MSB    = 11;
    localparam int unsigned OP_LSB    = 9;
    localparam int unsigned RD_MSB    = 8;
    localparam int unsigned RD_LSB    = 7;
    localparam int unsigned RS1_MSB   = 6;
    localparam int unsigned RS1_LSB   = 5;
    localparam int unsigned RS2_MSB   = 4;
    localparam int unsigned RS2_LSB   = 3;
    localparam int unsigned FUNCT_MSB = 2;
    localparam int unsigned IMM_MSB   = 6;
    localparam int unsigned TGT_MSB   = 3;

    typedef enum logic {StLoad, StExec} phase_e;

endpackage

// File: rtl/tinysoc_alu.sv
// Purely combinational 8-bit ALU.
// Ports: a, b - operands; funct - operation select; y - result.
module tinysoc_alu
    import tinysoc_user_module_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] funct,
    output logic [7:0] y
);

    always_comb begin
        y = a;
        case (funct)
            FN_ADD:  y = a + b;
            FN_SUB:  y = a - b;
            FN_AND:  y = a & b;
            FN_OR:   y = a | b;
            FN_XOR:  y = a ^ b;
            FN_SHL:  y = {a[6:0], 1'b0};
            FN_SHR:  y = {1'b0, a[7:1]};
            FN_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/tinysoc_user_module.sv
// Tiny 4-register 8-bit CPU for a TinyTapeout user slot.
// After reset the 16x12 program memory is loaded 6 bits per clock from the
// input pins, then the program runs forever, one instruction per clock.
// Ports: io_in[0] - clock; io_in[1] - async active-high reset;
//        io_in[7:2] - program chunk (load phase only);
//        io_out - R3 while executing, 0 during reset and load.
module tinysoc_user_module
    import tinysoc_user_module_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic               clk;
    logic               rst;
    logic [CHUNK_W-1:0] chunk;

    assign clk   = io_in[0];
    assign rst   = io_in[1];
    assign chunk = io_in[7:2];

    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CHUNK_W-1:0] low_q;
    instr_t             imem [16];
    data_t              regs [4];
    pc_t                pc_q, pc_d;

    logic load_active;
    logic exec_active;
    logic imem_we;

    // ---------------- load/exec phase FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= StLoad;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        // The odd cycle that writes imem[15] is the last load cycle.
        if (phase_q == StLoad && cnt_q == 5'd31) begin
            phase_d = StExec;
        end
    end

    always_comb begin
        load_active = (phase_q == StLoad);
        exec_active = (phase_q == StExec);
        imem_we     = load_active & cnt_q[0];
        io_out      = exec_active ? regs[3] : '0;
    end

    // ---------------- serial program load ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            low_q <= '0;
        end else if (load_active) begin
            cnt_q <= cnt_q + 5'd1;
            if (!cnt_q[0]) begin
                low_q <= chunk;
            end
        end
    end

    // Program memory survives reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[cnt_q[4:1]] <= {chunk, low_q};
        end
    end

    // ---------------- decode / execute ----------------
    instr_t     instr;
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [2:0] funct;
    logic [6:0] imm7;
    pc_t        tgt;
    data_t      alu_y;
    logic       rf_we;
    data_t      rf_wdata;

    always_comb begin
        instr = imem[pc_q];
        op    = instr[OP_MSB:OP_LSB];
        rd    = instr[RD_MSB:RD_LSB];
        rs1   = instr[RS1_MSB:RS1_LSB];
        rs2   = instr[RS2_MSB:RS2_LSB];
        funct = instr[FUNCT_MSB:0];
        imm7  = instr[IMM_MSB:0];
        tgt   = instr[TGT_MSB:0];
    end

    tinysoc_alu u_alu (
        .a     (regs[rs1]),
        .b     (regs[rs2]),
        .funct (funct),
        .y     (alu_y)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_y;
        pc_d     = pc_q + 4'd1;
        case (op)
            OP_ALU: begin
                rf_we = 1'b1;
            end
            OP_BEQZ: begin
                if (regs[rd] == '0) begin
                    pc_d = tgt;
                end
            end
            OP_IMM: begin
                rf_we    = 1'b1;
                rf_wdata = {1'b0, imm7};
            end
            OP_JUMP: begin
                pc_d = regs[rs2][PC_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (exec_active) begin
            pc_q <= pc_d;
            if (rf_we) begin
                regs[rd] <= rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_tinysoc_user_module.sv
module tb_tinysoc_user_module;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] data = '0;
    wire  [7:0] io_in;
    wire  [7:0] io_out;

    assign io_in = {data, rst, clk};

    tinysoc_user_module dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] prog [16];

    localparam logic [7:0] SWEEP [8] = '{8'h69, 8'h4B, 8'h0A, 8'h5F,
                                         8'h55, 8'hB4, 8'h2D, 8'h5A};

    task automatic clear_prog;
        for (int i = 0; i < 16; i++) prog[i] = '0;
    endtask

    // Called at the negedge on which reset was released; returns at the
    // negedge following the 32nd load edge.
    task automatic load_words(input int n);
        for (int w = 0; w < n; w++) begin
            data = prog[w][5:0];
            checks++;
            if (io_out !== 8'h00) begin
                failures++;
                $display("FAIL load_low w=%0d: io_out=%0h expected 0", w, io_out);
            end
            @(negedge clk);
            data = prog[w][11:6];
            checks++;
            if (io_out !== 8'h00) begin
                failures++;
                $display("FAIL load_high w=%0d: io_out=%0h expected 0", w, io_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (io_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_out: io_out=%0h expected 0", io_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clear_prog();
        prog[0] = 12'h784;  // IMM R3 = 4
        prog[1] = 12'h701;  // IMM R2 = 1
        prog[2] = 12'h1F0;  // ALU add R3 = R3 + R2
        prog[3] = 12'h810;  // JUMP R2 -> 1
        do_reset();
        load_words(16);
    endtask

    task automatic test_demo_loop;
        run(1);
        checks++;
        if (io_out !== 8'd4) begin failures++; $display("FAIL demo_e1: io_out=%0d expected 4", io_out); end
        run(1);
        checks++;
        if (io_out !== 8'd4) begin failures++; $display("FAIL demo_e2: io_out=%0d expected 4", io_out); end
        run(1);
        checks++;
        if (io_out !== 8'd5) begin failures++; $display("FAIL demo_e3: io_out=%0d expected 5", io_out); end
        run(3);
        checks++;
        if (io_out !== 8'd6) begin failures++; $display("FAIL demo_e6: io_out=%0d expected 6", io_out); end
        run(3);
        checks++;
        if (io_out !== 8'd7) begin failures++; $display("FAIL demo_e9: io_out=%0d expected 7", io_out); end
        run(746);
        checks++;
        if (io_out !== 8'd255) begin failures++; $display("FAIL demo_e755: io_out=%0d expected 255", io_out); end
        run(1);
        checks++;
        if (io_out !== 8'd0) begin failures++; $display("FAIL demo_wrap: io_out=%0d expected 0", io_out); end
    endtask

    // Reset during the demo loop, then reload with the ALU sweep program.
    task automatic test_reset_mid_exec;
        run(5);
        checks++;
        if (io_out !== 8'd1) begin failures++; $display("FAIL pre_reset: io_out=%0d expected 1", io_out); end
        clear_prog();
        prog[0] = 12'h6DA;  // IMM R1 = 0x5A
        prog[1] = 12'h70F;  // IMM R2 = 0x0F
        for (int f = 0; f < 8; f++) prog[2+f] = 12'h1B0 | 12'(f);  // R3 = R1 f R2
        do_reset();
        load_words(16);
        run(2);
        checks++;
        if (io_out !== 8'h00) begin failures++; $display("FAIL sweep_pre: io_out=%0h expected 0", io_out); end
        for (int f = 0; f < 8; f++) begin
            run(1);
            checks++;
            if (io_out !== SWEEP[f]) begin
                failures++;
                $display("FAIL alu_sweep f=%0d: io_out=%0h expected %0h", f, io_out, SWEEP[f]);
            end
        end
    endtask

    task automatic test_beqz(input logic r1_val);
        clear_prog();
        prog[0] = r1_val ? 12'h681 : 12'h680;  // IMM R1 = r1_val
        prog[1] = 12'h485;  // BEQZ R1 -> 5
        prog[2] = 12'h783;  // IMM R3 = 3
        prog[3] = 12'h403;  // BEQZ R0 -> 3 (self-loop)
        prog[5] = 12'h787;  // IMM R3 = 7
        prog[6] = 12'h406;  // BEQZ R0 -> 6 (self-loop)
        do_reset();
        if (r1_val == 1'b0) begin
            // Abort a load part-way; the next load must start at imem[0].
            load_words(5);
            do_reset();
        end
        load_words(16);
        run(2);
        checks++;
        if (io_out !== 8'd0) begin failures++; $display("FAIL beqz_e2 r1=%0d: io_out=%0d expected 0", r1_val, io_out); end
        run(1);
        checks++;
        if (io_out !== (r1_val ? 8'd3 : 8'd7)) begin
            failures++;
            $display("FAIL beqz_e3 r1=%0d: io_out=%0d expected %0d", r1_val, io_out, r1_val ? 3 : 7);
        end
        run(5);
        checks++;
        if (io_out !== (r1_val ? 8'd3 : 8'd7)) begin
            failures++;
            $display("FAIL beqz_loop r1=%0d: io_out=%0d expected %0d", r1_val, io_out, r1_val ? 3 : 7);
        end
    endtask

    task automatic test_pc_wrap;
        clear_prog();
        prog[0]  = 12'h781;  // IMM R3 = 1
        prog[15] = 12'h789;  // IMM R3 = 9
        do_reset();
        load_words(16);
        run(1);
        checks++;
        if (io_out !== 8'd1) begin failures++; $display("FAIL wrap_e1: io_out=%0d expected 1", io_out); end
        run(14);
        checks++;
        if (io_out !== 8'd1) begin failures++; $display("FAIL wrap_e15: io_out=%0d expected 1", io_out); end
        run(1);
        checks++;
        if (io_out !== 8'd9) begin failures++; $display("FAIL wrap_e16: io_out=%0d expected 9", io_out); end
        run(1);
        checks++;
        if (io_out !== 8'd1) begin failures++; $display("FAIL wrap_e17: io_out=%0d expected 1", io_out); end
    endtask

    initial begin
        test_reset();
        test_demo_loop();
        test_reset_mid_exec();
        test_beqz(1'b0);
        test_beqz(1'b1);
        test_pc_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
